load_counter: RTL and testbench

Loadable synchronous up-counter with parallel load, count enable and terminal-count flag. Used wherever a module needs a presettable event or cycle counter, for example as a timeout, a sequencer step index or a divider stage. Load has priority over counting, and the counter wraps modulo 2^WIDTH by default.

---
 rtl/load_counter_pkg.sv | 17 +
 rtl/load_counter_next.sv | 56 +++++
 rtl/load_counter.sv | 55 +++++
 tb/tb_load_counter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/load_counter_pkg.sv
// -----------------------------------------------------------------------------
// load_counter_pkg
// Shared constants and helpers for the loadable up-counter.
//   DEFAULT_WIDTH : default counter width (4 bits)
//   all_ones_f()  : all-ones value for a given width (1..32), returned in 32 bits
//                   so callers can cast it down to their own WIDTH.
// -----------------------------------------------------------------------------
package load_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // All-ones mask of the requested width, right-aligned in 32 bits.
    function automatic logic [31:0] all_ones_f(input int unsigned width);
        return 32'hFFFF_FFFF >> (32'd32 - width);
    endfunction

endpackage

// File: rtl/load_counter_next.sv
// -----------------------------------------------------------------------------
// load_counter_next
// Combinational next-state and terminal-count logic for load_counter.
// Configuration macro: LOAD_COUNTER_SATURATE_EN
//   undefined : an enabled increment at all-ones wraps to 0
//   defined   : an enabled increment at all-ones holds at all-ones
// Ports:
//   count_i      : current counter value
//   data_in_i    : parallel-load value
//   load_i       : load strobe (wins over enable)
//   enable_i     : count enable
//   count_next_o : value the register takes on the next edge
//   tc_o         : terminal count (all-ones, enabled, not loading)
// -----------------------------------------------------------------------------
module load_counter_next
    import load_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             load_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] count_next_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones_f(WIDTH));
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);

    logic at_max_s;

    // Priority select of the next count value and terminal-count decode.
    always_comb begin
        at_max_s     = (count_i == ALL_ONES);
        tc_o         = at_max_s & enable_i & ~load_i;
        count_next_o = count_i;
        if (load_i) begin
            count_next_o = data_in_i;
        end else if (enable_i) begin
`ifdef LOAD_COUNTER_SATURATE_EN
            if (at_max_s) begin
                count_next_o = ALL_ONES;
            end else begin
                count_next_o = count_i + ONE;
            end
`else
            // WIDTH-bit addition drops the carry, giving the modulo wrap.
            count_next_o = count_i + ONE;
`endif
        end else begin
            count_next_o = count_i;
        end
    end

endmodule

// File: rtl/load_counter.sv
// -----------------------------------------------------------------------------
// load_counter
// Presettable synchronous up-counter with parallel load, count enable and a
// combinational terminal-count flag. Load has priority over counting.
// Configuration macro: LOAD_COUNTER_SATURATE_EN (saturate at all-ones instead
// of wrapping; handled inside load_counter_next).
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, clears count to 0
//   load    : synchronous parallel-load strobe
//   enable  : count enable
//   data_in : value loaded when load is high
//   count   : current counter value (register output)
//   tc      : terminal count, high when count is all-ones, enable=1, load=0
// -----------------------------------------------------------------------------
module load_counter
    import load_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    load_counter_next #(
        .WIDTH        (WIDTH)
    ) u_next (
        .count_i      (count_q),
        .data_in_i    (data_in),
        .load_i       (load),
        .enable_i     (enable),
        .count_next_o (count_d),
        .tc_o         (tc)
    );

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_load_counter.sv
// -----------------------------------------------------------------------------
// tb_load_counter
// Directed self-checking bench for load_counter (WIDTH = 4).
// Expected values follow the wrap or saturate behaviour selected by
// LOAD_COUNTER_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_load_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic       enable;
    logic [3:0] data_in;
    logic [3:0] count;
    logic       tc;

    int tests_run    = 0;
    int tests_failed = 0;

    load_counter #(
        .WIDTH   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .enable  (enable),
        .data_in (data_in),
        .count   (count),
        .tc      (tc)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then step away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] wrap_exp [5];
    logic [3:0] cnt_exp  [4];

    initial begin
        cnt_exp = '{4'd6, 4'd7, 4'd8, 4'd9};
`ifdef LOAD_COUNTER_SATURATE_EN
        wrap_exp = '{4'd13, 4'd14, 4'd15, 4'd15, 4'd15};
`else
        wrap_exp = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
`endif

        // Reset held for 12 ns, spanning the edge at 5 ns.
        rst     = 1'b1;
        load    = 1'b0;
        enable  = 1'b0;
        data_in = 4'd0;
        #2;
        check_val("rst_count_t2", 32'(count), 32'd0);
        check_val("rst_tc_t2", 32'(tc), 32'd0);
        #5;
        check_val("rst_count_t7", 32'(count), 32'd0);
        check_val("rst_tc_t7", 32'(tc), 32'd0);
        #5;
        rst     = 1'b0;
        data_in = 4'd5;
        load    = 1'b1;
        enable  = 1'b1;
        #0;
        check_val("rel_count", 32'(count), 32'd0);

        // Load beats enable on the same edge.
        tick();
        check_val("load_prio", 32'(count), 32'd5);
        check_val("load_tc", 32'(tc), 32'd0);

        // Count four steps; data_in changes must be ignored while load=0.
        load    = 1'b0;
        data_in = 4'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("count_%0d", i), 32'(count), 32'(cnt_exp[i]));
        end

        // Hold for two edges.
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val($sformatf("hold_%0d", i), 32'(count), 32'd9);
        end

        // Reload.
        data_in = 4'd12;
        load    = 1'b1;
        tick();
        check_val("reload", 32'(count), 32'd12);

        // Wrap (or saturate) through all-ones; tc only while count = 15.
        load   = 1'b0;
        enable = 1'b1;
        #1;
        check_val("tc_at_12", 32'(tc), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val($sformatf("wrap_cnt_%0d", i), 32'(count), 32'(wrap_exp[i]));
            check_val($sformatf("wrap_tc_%0d", i), 32'(tc), 32'(wrap_exp[i] == 4'd15));
        end

        // Load all-ones with enable high: tc gated by load, then by enable.
        data_in = 4'd15;
        load    = 1'b1;
        enable  = 1'b1;
        tick();
        check_val("ld15_count", 32'(count), 32'd15);
        check_val("ld15_tc_load", 32'(tc), 32'd0);
        load   = 1'b0;
        enable = 1'b0;
        #1;
        check_val("ld15_tc_noen", 32'(tc), 32'd0);
        enable = 1'b1;
        #1;
        check_val("ld15_tc_en", 32'(tc), 32'd1);
        tick();
`ifdef LOAD_COUNTER_SATURATE_EN
        check_val("ld15_step", 32'(count), 32'd15);
`else
        check_val("ld15_step", 32'(count), 32'd0);
`endif

        // Load off all-ones, then count up to 7.
        data_in = 4'd5;
        load    = 1'b1;
        tick();
        check_val("pre_rst_5", 32'(count), 32'd5);
        load = 1'b0;
        tick();
        tick();
        check_val("pre_rst_7", 32'(count), 32'd7);

        // Asynchronous reset between edges.
        rst = 1'b1;
        #1;
        check_val("async_rst_count", 32'(count), 32'd0);
        check_val("async_rst_tc", 32'(tc), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check_val("async_rel_hold", 32'(count), 32'd0);
        tick();
        check_val("resume_1", 32'(count), 32'd1);
        tick();
        check_val("resume_2", 32'(count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
